// File: rtl/t_port_receiver.sv
// t_port_receiver: captures CPU output-port writes into a small FIFO.
// It tracks the most recent accepted byte and counts writes that were
// dropped because the FIFO was full.
module t_port_receiver #(
    parameter int DEPTH = 8,
    parameter int CW    = 4
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic [7:0]    T,
    input  logic          TWrite,
    output logic [7:0]    OutData,
    output logic          OutValid,
    input  logic          OutReady,
    output logic [CW-1:0] Count,
    output logic          Full,
    output logic [7:0]    LastT,
    output logic          Overflow,
    output logic [7:0]    DropCount,
    input  logic          ClearOverflow
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count_q;
    logic          pop;
    logic          push;
    logic          drop;

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    // Handshake decode and output view, all derived from registered state.
    // A pop frees a slot, so a write to a full FIFO is still accepted when
    // the consumer takes the head in the same cycle.
    always_comb begin
        OutValid = (count_q != '0);
        Full     = (count_q == CW'(DEPTH));
        pop      = OutValid && OutReady;
        push     = TWrite && (!Full || pop);
        drop     = TWrite && Full && !pop;
        Count    = count_q;
        OutData  = OutValid ? mem[rd_ptr] : '0;
    end

    // Storage array; gated by Reset so a write in the reset cycle is discarded.
    always_ff @(posedge Clock) begin
        if (Reset && push) begin
            mem[wr_ptr] <= T;
        end
    end

    // Pointers and occupancy count.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) wr_ptr <= next_ptr(wr_ptr);
            if (pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Last accepted byte.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            LastT <= '0;
        end else if (push) begin
            LastT <= T;
        end
    end

    // Sticky overflow flag and saturating drop counter; a drop coinciding
    // with a clear leaves the first drop of the new window recorded.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            Overflow  <= 1'b0;
            DropCount <= '0;
        end else if (ClearOverflow) begin
            Overflow  <= drop;
            DropCount <= drop ? 8'd1 : 8'd0;
        end else if (drop) begin
            Overflow <= 1'b1;
            if (DropCount != 8'hFF) begin
                DropCount <= DropCount + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_t_port_receiver.sv
// Self-checking bench for t_port_receiver: directed scenarios then random
// traffic, all compared against a queue-based reference model.
module tb_t_port_receiver;

    localparam int DEPTH = 8;
    localparam int CW    = 4;

    logic          Clock = 1'b0;
    logic          Reset;
    logic [7:0]    T;
    logic          TWrite;
    logic [7:0]    OutData;
    logic          OutValid;
    logic          OutReady;
    logic [CW-1:0] Count;
    logic          Full;
    logic [7:0]    LastT;
    logic          Overflow;
    logic [7:0]    DropCount;
    logic          ClearOverflow;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [7:0] mq[$];
    logic [7:0] m_last;
    logic       m_ovf;
    int         m_drops;

    t_port_receiver #(.DEPTH(DEPTH), .CW(CW)) dut (
        .Clock(Clock), .Reset(Reset), .T(T), .TWrite(TWrite),
        .OutData(OutData), .OutValid(OutValid), .OutReady(OutReady),
        .Count(Count), .Full(Full), .LastT(LastT), .Overflow(Overflow),
        .DropCount(DropCount), .ClearOverflow(ClearOverflow)
    );

    // 100 MHz clock
    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock edge using the inputs presented to it.
    task automatic model_edge();
        bit pop, push, drop;
        if (!Reset) begin
            mq.delete();
            m_last = 8'h00; m_ovf = 1'b0; m_drops = 0;
            return;
        end
        pop  = (mq.size() != 0) && OutReady;
        push = TWrite && ((mq.size() < DEPTH) || pop);
        drop = TWrite && !push;
        if (pop) void'(mq.pop_front());
        if (push) begin
            mq.push_back(T);
            m_last = T;
        end
        if (ClearOverflow) begin
            m_ovf = drop; m_drops = drop ? 1 : 0;
        end else if (drop) begin
            m_ovf = 1'b1;
            if (m_drops < 255) m_drops++;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".Count"},     32'(Count),     32'(mq.size()));
        chk({tag, ".OutValid"},  32'(OutValid),  32'(mq.size() != 0));
        chk({tag, ".OutData"},   32'(OutData),   (mq.size() != 0) ? 32'(mq[0]) : 32'h0);
        chk({tag, ".Full"},      32'(Full),      32'(mq.size() == DEPTH));
        chk({tag, ".LastT"},     32'(LastT),     32'(m_last));
        chk({tag, ".Overflow"},  32'(Overflow),  32'(m_ovf));
        chk({tag, ".DropCount"}, 32'(DropCount), 32'(m_drops));
    endtask

    // Drive one cycle, let the edge happen, update model, then sample.
    task automatic step(input logic rst, input logic wr, input logic [7:0] d,
                        input logic rdy, input logic clr, input string tag,
                        input bit full_check);
        Reset = rst; TWrite = wr; T = d; OutReady = rdy; ClearOverflow = clr;
        @(posedge Clock);
        model_edge();
        #1;
        if (full_check) check_all(tag);
    endtask

    initial begin
        Reset = 1'b0; TWrite = 1'b0; T = 8'h00; OutReady = 1'b0; ClearOverflow = 1'b0;
        #1;

        // Reset state
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, "reset", 1);
        step(1'b0, 1'b1, 8'h55, 1'b1, 1'b0, "reset2", 1);
        chk("reset.Count0", 32'(Count), 32'd0);
        chk("reset.OutData0", 32'(OutData), 32'd0);

        // Single write, one-edge latency, then pop
        step(1'b1, 1'b1, 8'h2A, 1'b0, 1'b0, "single.wr", 1);
        chk("single.OutData", 32'(OutData), 32'h2A);
        chk("single.LastT", 32'(LastT), 32'h2A);
        step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, "single.pop", 1);
        chk("single.empty", 32'(OutValid), 32'd0);

        // Fill and drain twice so pointers wrap
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 1; i <= DEPTH; i++)
                step(1'b1, 1'b1, 8'(pass * DEPTH + i), 1'b0, 1'b0, "fill", 1);
            chk("fill.Full", 32'(Full), 32'd1);
            for (int i = 1; i <= DEPTH; i++) begin
                chk("drain.order", 32'(OutData), 32'(pass * DEPTH + i));
                step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, "drain", 1);
            end
        end

        // Overflow: fill, 10 dropped writes, clear, then drain 1..8
        for (int i = 1; i <= DEPTH; i++)
            step(1'b1, 1'b1, 8'(i), 1'b0, 1'b0, "ovf.fill", 1);
        for (int i = 0; i < 10; i++)
            step(1'b1, 1'b1, 8'(8'hE0 + i), 1'b0, 1'b0, "ovf.drop", 1);
        chk("ovf.DropCount10", 32'(DropCount), 32'd10);
        chk("ovf.flag", 32'(Overflow), 32'd1);
        chk("ovf.LastT", 32'(LastT), 32'd8);
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, "ovf.clear", 1);
        chk("ovf.cleared", 32'(DropCount), 32'd0);
        // Drop in the same cycle as clear
        step(1'b1, 1'b1, 8'hEE, 1'b0, 1'b1, "ovf.clrdrop", 1);
        chk("ovf.clrdrop", 32'(DropCount), 32'd1);
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, "ovf.clear2", 1);

        // Full with simultaneous push and pop
        step(1'b1, 1'b1, 8'h99, 1'b1, 1'b0, "fullpp", 1);
        chk("fullpp.Count", 32'(Count), 32'd8);
        chk("fullpp.head", 32'(OutData), 32'd2);
        chk("fullpp.Overflow", 32'(Overflow), 32'd0);
        for (int i = 0; i < DEPTH; i++)
            step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, "fullpp.drain", 1);

        // Empty with simultaneous push and ready: push only
        step(1'b1, 1'b1, 8'h3C, 1'b1, 1'b0, "emptypp", 1);
        chk("emptypp.Count", 32'(Count), 32'd1);
        step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, "emptypp.pop", 1);

        // Reset mid-stream with a write in the reset cycle
        for (int i = 0; i < 5; i++)
            step(1'b1, 1'b1, 8'(8'h70 + i), 1'b0, 1'b0, "rst.fill", 1);
        step(1'b1, 1'b1, 8'hAB, 1'b0, 1'b0, "rst.fill6", 1);
        step(1'b1, 1'b1, 8'hAC, 1'b1, 1'b0, "rst.busy", 1);
        step(1'b0, 1'b1, 8'hDD, 1'b1, 1'b0, "rst.mid", 1);
        chk("rst.LastT", 32'(LastT), 32'd0);
        step(1'b1, 1'b1, 8'h11, 1'b0, 1'b0, "rst.first", 1);
        chk("rst.firstpush", 32'(OutData), 32'h11);

        // Saturation: 300 drops
        for (int i = 1; i < DEPTH; i++)
            step(1'b1, 1'b1, 8'(i), 1'b0, 1'b0, "sat.fill", 0);
        for (int i = 0; i < 300; i++)
            step(1'b1, 1'b1, 8'(i), 1'b0, 1'b0, "sat.drop", 0);
        check_all("sat");
        chk("sat.DropCount", 32'(DropCount), 32'd255);
        step(1'b1, 1'b1, 8'h01, 1'b0, 1'b0, "sat.hold", 1);
        chk("sat.held", 32'(DropCount), 32'd255);
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, "sat.clear", 1);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 199) != 0),
                 ($urandom_range(0, 9) < 6),
                 8'($urandom),
                 ($urandom_range(0, 9) < 5),
                 ($urandom_range(0, 49) == 0),
                 "rand", 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
